// File: rtl/jtag_selftest_pkg.sv
// Shared state encoding and pattern-phase constants for the Bus Blaster
// loopback self-test sequencer.
package jtag_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  // Step index width covers the largest legal run (16 pairs -> 34 steps).
  localparam int STEP_W   = 6;
  localparam int PH_ONES  = 1;
  localparam int PH_WALK1 = 2;

  function automatic int nsteps(input int n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/jtag_selftest_if.sv
// Firmware-side control/status and loopback pins of the self-test sequencer.
interface jtag_selftest_if #(
  parameter int N_PAIRS = 8
);
  logic               start;
  logic               abort;
  logic [N_PAIRS-1:0] sense;
  logic [N_PAIRS-1:0] drive;
  logic               drive_oe;
  logic               busy;
  logic               done;
  logic               pass;
  logic [N_PAIRS-1:0] fail_mask;
  logic [7:0]         err_cnt;
  logic               led;

  modport master (
    output start, abort, sense,
    input  drive, drive_oe, busy, done, pass, fail_mask, err_cnt, led
  );

  modport slave (
    input  start, abort, sense,
    output drive, drive_oe, busy, done, pass, fail_mask, err_cnt, led
  );
endinterface

// File: rtl/jtag_selftest_patgen.sv
// Maps a self-test step index to its loopback pattern: zeros, ones,
// walking one, then walking zero.
module jtag_selftest_patgen
  import jtag_selftest_pkg::*;
#(
  parameter int N_PAIRS = 8
) (
  input  logic [STEP_W-1:0]  step_i,
  output logic [N_PAIRS-1:0] pattern_o
);

  localparam logic [STEP_W-1:0]  ONES_STEP = STEP_W'(PH_ONES);
  localparam logic [STEP_W-1:0]  W1_BASE   = STEP_W'(PH_WALK1);
  localparam logic [STEP_W-1:0]  W0_BASE   = STEP_W'(PH_WALK1 + N_PAIRS);
  localparam logic [STEP_W-1:0]  END_STEP  = STEP_W'(nsteps(N_PAIRS));
  localparam logic [N_PAIRS-1:0] ONE_HOT   = N_PAIRS'(1);

  always_comb begin
    pattern_o = '0;
    if (step_i == ONES_STEP) begin
      pattern_o = '1;
    end else if (step_i >= W1_BASE && step_i < W0_BASE) begin
      pattern_o = ONE_HOT << (step_i - W1_BASE);
    end else if (step_i >= W0_BASE && step_i < END_STEP) begin
      pattern_o = ~(ONE_HOT << (step_i - W0_BASE));
    end
  end

endmodule

// File: rtl/jtag_selftest_seq.sv
// Loopback self-test sequencer: drives each pattern, samples the synchronised
// sense pins, accumulates a fail mask / error count and shows status on the LED.
module jtag_selftest_seq
  import jtag_selftest_pkg::*;
#(
  parameter int          N_PAIRS       = 8,
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [23:0] BLINK_DIV     = 24'd6000000
) (
  input  logic           clk,
  input  logic           rst_n,
  jtag_selftest_if.slave bus
);

  localparam int                  NSTEPS      = nsteps(N_PAIRS);
  localparam logic [STEP_W-1:0]   LAST_STEP   = STEP_W'(NSTEPS - 1);
  localparam int                  SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [23:0]         BLINK_LAST  = BLINK_DIV - 24'd1;

  state_e              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [23:0]         blinkCnt_q, blinkCnt_d;
  logic                blink_q, blink_d;
  logic [N_PAIRS-1:0]  senseMeta_q, senseSync_q;
  logic [N_PAIRS-1:0]  failMask_q, failMask_d;
  logic [7:0]          errCnt_q, errCnt_d;
  logic [N_PAIRS-1:0]  pattern;
  logic [N_PAIRS-1:0]  mism;
  logic                active;
  logic                isDone;

  jtag_selftest_patgen #(
    .N_PAIRS (N_PAIRS)
  ) u_patgen (
    .step_i    (step_q),
    .pattern_o (pattern)
  );

  assign mism = senseSync_q ^ pattern;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    settle_d   = settle_q;
    failMask_d = failMask_q;
    errCnt_d   = errCnt_q;
    blinkCnt_d = blinkCnt_q;
    blink_d    = blink_q;

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) begin
          if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d = '0;
            blink_d    = ~blink_q;
          end else begin
            blinkCnt_d = blinkCnt_q + 24'd1;
          end
        end
        if (bus.start) begin
          state_d    = DRIVE;
          step_d     = '0;
          settle_d   = '0;
          failMask_d = '0;
          errCnt_d   = '0;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        failMask_d = failMask_q | mism;
        if (mism != '0 && errCnt_q != 8'hFF) begin
          errCnt_d = errCnt_q + 8'd1;
        end
        if (step_q == LAST_STEP) begin
          state_d    = DONE;
          blinkCnt_d = '0;
          blink_d    = 1'b1;
        end else begin
          step_d  = step_q + STEP_W'(1);
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition above, including a same-cycle START.
    if (bus.abort) begin
      state_d    = IDLE;
      step_d     = '0;
      settle_d   = '0;
      failMask_d = '0;
      errCnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      settle_q    <= '0;
      blinkCnt_q  <= '0;
      blink_q     <= 1'b0;
      senseMeta_q <= '0;
      senseSync_q <= '0;
      failMask_q  <= '0;
      errCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      settle_q    <= settle_d;
      blinkCnt_q  <= blinkCnt_d;
      blink_q     <= blink_d;
      senseMeta_q <= bus.sense;
      senseSync_q <= senseMeta_q;
      failMask_q  <= failMask_d;
      errCnt_q    <= errCnt_d;
    end
  end

  // Outputs decode straight from state so reset clears the pins without a clock.
  assign active        = (state_q == DRIVE) || (state_q == SAMPLE);
  assign isDone        = (state_q == DONE);
  assign bus.drive     = active ? pattern : '0;
  assign bus.drive_oe  = active;
  assign bus.busy      = active;
  assign bus.done      = isDone;
  assign bus.pass      = isDone && (failMask_q == '0);
  assign bus.fail_mask = failMask_q;
  assign bus.err_cnt   = errCnt_q;
  assign bus.led       = active || (isDone && ((failMask_q == '0) || blink_q));

endmodule

// File: tb/tb_jtag_selftest_seq.sv
// Scoreboard bench for jtag_selftest_seq: directed loopback fault scenarios,
// restart/abort/reset handling and LED blink behaviour.
module tb_jtag_selftest_seq;

  localparam int N          = 8;
  localparam int SETTLE     = 4;
  localparam int BLINK      = 4;
  localparam int RUN_CYCLES = 90;

  localparam int MODE_GOOD    = 0;
  localparam int MODE_STUCK3  = 1;
  localparam int MODE_SWAP56  = 2;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] err;
    logic       pass;
  } expect_t;

  logic    clk;
  logic    rst_n;
  int      senseMode;
  int      vectorsApplied;
  int      miscompares;
  expect_t expQ[$];

  jtag_selftest_if #(.N_PAIRS(N)) bus ();

  jtag_selftest_seq #(
    .N_PAIRS       (N),
    .SETTLE_CYCLES (SETTLE),
    .BLINK_DIV     (24'(BLINK))
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loopback wiring model, optionally with a planted board fault.
  always_comb begin
    case (senseMode)
      MODE_STUCK3: bus.sense = bus.drive & 8'hF7;
      MODE_SWAP56: bus.sense = {bus.drive[7], bus.drive[5], bus.drive[6], bus.drive[4:0]};
      default:     bus.sense = bus.drive;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int mode, input logic [7:0] mask, input logic [7:0] err,
                               input logic pass, input bit expectDone);
    expect_t e;
    senseMode = mode;
    if (expectDone) begin
      e.mask = mask;
      e.err  = err;
      e.pass = pass;
      expQ.push_back(e);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_done_seen"}, 32'(bus.done), 32'd1);
  endtask

  task automatic checkLed(input string name, input bit blinking);
    for (int i = 0; i < 3 * BLINK; i++) begin
      checkOutput(name, 32'(bus.led), blinking ? 32'(((i / BLINK) % 2) == 0) : 32'd1);
      @(negedge clk);
    end
  endtask

  // Monitor: on each DONE rising edge pops the expected result and compares.
  initial begin : monitor
    logic    prevDone;
    logic    prevBusy;
    int      busyCycles;
    expect_t e;
    prevDone   = 1'b0;
    prevBusy   = 1'b0;
    busyCycles = 0;
    forever begin
      @(negedge clk);
      if (bus.busy) busyCycles = prevBusy ? busyCycles + 1 : 1;
      if (bus.done && !prevDone) begin
        if (expQ.size() == 0) begin
          vectorsApplied++;
          miscompares++;
          $display("[TB] FAIL sb_unexpected_done: got done=1, expected no completion");
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_fail_mask", 32'(bus.fail_mask), 32'(e.mask));
          checkOutput("sb_err_cnt", 32'(bus.err_cnt), 32'(e.err));
          checkOutput("sb_pass", 32'(bus.pass), 32'(e.pass));
          checkOutput("sb_busy_cycles", 32'(busyCycles), 32'(RUN_CYCLES));
          checkOutput("sb_led_at_done", 32'(bus.led), 32'd1);
          checkOutput("sb_drive_oe_at_done", 32'(bus.drive_oe), 32'd0);
        end
      end
      prevDone = bus.done;
      prevBusy = bus.busy;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    vectorsApplied = 0;
    miscompares    = 0;
    senseMode      = MODE_GOOD;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    rst_n          = 1'b0;

    #12;
    checkOutput("rst_drive", 32'(bus.drive), 32'd0);
    checkOutput("rst_drive_oe", 32'(bus.drive_oe), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_pass", 32'(bus.pass), 32'd0);
    checkOutput("rst_fail_mask", 32'(bus.fail_mask), 32'd0);
    checkOutput("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    checkOutput("rst_led", 32'(bus.led), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    $display("[TB] perfect loopback");
    applyStimulus(MODE_GOOD, 8'h00, 8'd0, 1'b1, 1'b1);
    checkOutput("run_drive_step0", 32'(bus.drive), 32'h00);
    repeat (5) @(negedge clk);
    checkOutput("run_drive_step1", 32'(bus.drive), 32'hFF);
    waitDone("good");
    checkLed("led_steady", 1'b0);

    $display("[TB] bit3 stuck at 0, restart from DONE");
    applyStimulus(MODE_STUCK3, 8'h08, 8'd9, 1'b0, 1'b1);
    waitDone("stuck3");
    checkLed("led_blink", 1'b1);

    $display("[TB] bits 5/6 swapped");
    applyStimulus(MODE_SWAP56, 8'h60, 8'd4, 1'b0, 1'b1);
    waitDone("swap56");

    $display("[TB] START repeated while busy");
    applyStimulus(MODE_GOOD, 8'h00, 8'd0, 1'b1, 1'b1);
    repeat (29) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("restart_ignored_busy", 32'(bus.busy), 32'd1);
    waitDone("restart_ignored");

    $display("[TB] ABORT mid-run");
    applyStimulus(MODE_STUCK3, 8'h00, 8'd0, 1'b0, 1'b0);
    repeat (39) @(negedge clk);
    checkOutput("pre_abort_err_cnt", 32'(bus.err_cnt), 32'd2);
    checkOutput("pre_abort_fail_mask", 32'(bus.fail_mask), 32'h08);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_fail_mask", 32'(bus.fail_mask), 32'd0);
    checkOutput("abort_err_cnt", 32'(bus.err_cnt), 32'd0);
    checkOutput("abort_drive_oe", 32'(bus.drive_oe), 32'd0);
    checkOutput("abort_led", 32'(bus.led), 32'd0);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("start_abort_idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("start_abort_idle_done", 32'(bus.done), 32'd0);

    applyStimulus(MODE_STUCK3, 8'h08, 8'd9, 1'b0, 1'b1);
    waitDone("after_abort");

    $display("[TB] async reset mid-step");
    applyStimulus(MODE_GOOD, 8'h00, 8'd0, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_drive_oe", 32'(bus.drive_oe), 32'd0);
    checkOutput("async_rst_drive", 32'(bus.drive), 32'd0);
    checkOutput("async_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("async_rst_led", 32'(bus.led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_rst_done", 32'(bus.done), 32'd0);
    checkOutput("post_rst_drive_oe", 32'(bus.drive_oe), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_queue_drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
